// File: rtl/tx_ds_arbiter.sv
// -----------------------------------------------------------------------------
// tx_ds_arbiter
//
// Chooses the next 9-bit link character for the DS encoder. Requesters are
// served in priority order: time-code, FCT (space available), data, NULL.
// A time-code goes out as ESC followed by {0,time}. A NULL goes out as ESC
// followed by FCT. The second character of each pair always follows its ESC,
// and no other request is served in between.
//
// The block also keeps the transmit credit. Each data character sent uses one
// credit. Each FCT received from the far end adds CREDIT_PER_FCT credits. An
// add that would go above CREDIT_MAX is dropped and creditError_o pulses.
//
// Ports
//   txClk            transmit clock; all logic runs on the rising edge
//   txReset_n        asynchronous, active-low reset
//   ready_i          encoder can take a character this cycle
//   reqTimecode_i    time-code request (level); timecode_i is sampled with ESC
//   reqSpaceAvail_i  FCT request (level)
//   reqData_i        data request (level); the character is on dat_i
//   reqIdle_i        NULL request (level)
//   fctRcvd_i        one-cycle pulse: an FCT arrived from the far end
//   ack*_o           one-cycle pulse: the matching request was consumed
//   valid_o, dat_o   one-cycle pulse with a new character; dat_o holds between
//   credit_o         current transmit credit
//   creditError_o    one-cycle pulse: a credit add was dropped (overflow)
// -----------------------------------------------------------------------------
module tx_ds_arbiter #(
  parameter int unsigned CREDIT_W       = 6,
  parameter int unsigned CREDIT_PER_FCT = 8,
  parameter int unsigned CREDIT_MAX     = 56
) (
  input  logic                txClk,
  input  logic                txReset_n,
  input  logic                ready_i,
  input  logic                reqTimecode_i,
  input  logic [7:0]          timecode_i,
  input  logic                reqSpaceAvail_i,
  input  logic                reqData_i,
  input  logic [8:0]          dat_i,
  input  logic                reqIdle_i,
  input  logic                fctRcvd_i,
  output logic                ackTimecode_o,
  output logic                ackSpaceAvail_o,
  output logic                ackData_o,
  output logic                ackIdle_o,
  output logic                valid_o,
  output logic [8:0]          dat_o,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                creditError_o
);

  localparam logic [8:0] CHAR_FCT = 9'h100;
  localparam logic [8:0] CHAR_ESC = 9'h103;

  // Credit arithmetic uses one extra bit so an overflow can be seen before
  // the result is truncated.
  localparam logic [CREDIT_W:0] CREDIT_ADD = (CREDIT_W+1)'(CREDIT_PER_FCT);
  localparam logic [CREDIT_W:0] CREDIT_LIM = (CREDIT_W+1)'(CREDIT_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TC2   = 2'd1,   // time-code second half is pending
    NULL2 = 2'd2    // FCT half of a NULL is pending
  } arbState_t;

  arbState_t           state, stateNext;
  logic [7:0]          tcLatched, tcLatchedNext;
  logic                validNext;
  logic [8:0]          datNext;
  logic                ackTimecodeNext, ackSpaceAvailNext, ackDataNext, ackIdleNext;
  logic [CREDIT_W-1:0] creditNext;
  logic                creditErrorNext;

  logic                issue;
  logic                datOk;
  logic                creditDec;
  logic [CREDIT_W:0]   creditSum;

  // A character may go out only when the encoder is ready and no character
  // went out last cycle. This gives at least one gap between characters.
  assign issue = ready_i && !valid_o;

  // N-chars are always legal. Of the control codes, only EOP (01) and EEP (10)
  // may come from the data path. FCT/ESC codes there are dropped.
  assign datOk = !dat_i[8] || (dat_i[1:0] == 2'b01) || (dat_i[1:0] == 2'b10);

  always_comb begin
    stateNext         = state;
    tcLatchedNext     = tcLatched;
    validNext         = 1'b0;
    datNext           = dat_o;
    ackTimecodeNext   = 1'b0;
    ackSpaceAvailNext = 1'b0;
    ackDataNext       = 1'b0;
    ackIdleNext       = 1'b0;
    creditDec         = 1'b0;

    if (issue) begin
      unique case (state)
        IDLE: begin
          if (reqTimecode_i) begin
            validNext       = 1'b1;
            datNext         = CHAR_ESC;
            ackTimecodeNext = 1'b1;
            tcLatchedNext   = timecode_i;
            stateNext       = TC2;
          end else if (reqSpaceAvail_i) begin
            validNext         = 1'b1;
            datNext           = CHAR_FCT;
            ackSpaceAvailNext = 1'b1;
          end else if (reqData_i && datOk && (credit_o != '0)) begin
            validNext   = 1'b1;
            datNext     = dat_i;
            ackDataNext = 1'b1;
            creditDec   = 1'b1;
          end else if (reqData_i && !datOk) begin
            // Drop the illegal character. It is not an issue, so nothing is
            // sent this cycle.
            ackDataNext = 1'b1;
          end else if (reqIdle_i) begin
            validNext   = 1'b1;
            datNext     = CHAR_ESC;
            ackIdleNext = 1'b1;
            stateNext   = NULL2;
          end
        end
        TC2: begin
          validNext = 1'b1;
          datNext   = {1'b0, tcLatched};
          stateNext = IDLE;
        end
        NULL2: begin
          validNext = 1'b1;
          datNext   = CHAR_FCT;
          stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // A decrement and an FCT increment in the same cycle are netted. On
  // overflow the increment is dropped, but the decrement still applies
  // because that data character was really sent.
  always_comb begin
    creditSum       = {1'b0, credit_o} - {{CREDIT_W{1'b0}}, creditDec}
                      + (fctRcvd_i ? CREDIT_ADD : '0);
    creditErrorNext = 1'b0;
    creditNext      = creditSum[CREDIT_W-1:0];
    if (creditSum > CREDIT_LIM) begin
      creditErrorNext = 1'b1;
      creditNext      = credit_o - {{(CREDIT_W-1){1'b0}}, creditDec};
    end
  end

  always_ff @(posedge txClk or negedge txReset_n) begin
    if (!txReset_n) begin
      state           <= IDLE;
      tcLatched       <= '0;
      valid_o         <= 1'b0;
      dat_o           <= '0;
      ackTimecode_o   <= 1'b0;
      ackSpaceAvail_o <= 1'b0;
      ackData_o       <= 1'b0;
      ackIdle_o       <= 1'b0;
      credit_o        <= '0;
      creditError_o   <= 1'b0;
    end else begin
      state           <= stateNext;
      tcLatched       <= tcLatchedNext;
      valid_o         <= validNext;
      dat_o           <= datNext;
      ackTimecode_o   <= ackTimecodeNext;
      ackSpaceAvail_o <= ackSpaceAvailNext;
      ackData_o       <= ackDataNext;
      ackIdle_o       <= ackIdleNext;
      credit_o        <= creditNext;
      creditError_o   <= creditErrorNext;
    end
  end

endmodule
